axi4_stream_frag_sched: RTL and testbench

- Packet-granular round-robin scheduler that shares one axi4_stream_pkt_frag instance between REQ_NUM AXI4-Stream requesters.
- Selects one requester per packet and muxes it onto pkt_o, which feeds the fragmenter's pkt_i.
- Drives the fragmenter's max_frag_size_i from a per-requester configuration table, held stable for the whole packet.
- Tags the packet's TDEST with the granted requester index.

---
 rtl/axi4_stream_frag_sched_pkg.sv | 26 ++
 rtl/axi4_stream_frag_sched_if.sv | 20 ++
 rtl/axi4_stream_frag_sched_rr_arb.sv | 31 +++
 rtl/axi4_stream_frag_sched.sv | 160 ++++++++++++++++
 tb/tb_axi4_stream_frag_sched.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_frag_sched_pkg.sv
// Shared state type, index width and round-robin search helper for the fragment scheduler.
package axi4_stream_frag_sched_pkg;

  localparam int REQ_NUM_MAX   = 16;
  localparam int REQ_IDX_WIDTH = $clog2(REQ_NUM_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_t;

  // First set bit of req_mask at or after ptr, wrapping. Unused upper mask bits
  // are zero, so wrapping at REQ_NUM_MAX gives the same order as wrapping at REQ_NUM.
  function automatic logic [REQ_IDX_WIDTH-1:0] rr_next(
    input logic [REQ_NUM_MAX-1:0]   req_mask,
    input logic [REQ_IDX_WIDTH-1:0] ptr
  );
    logic [REQ_IDX_WIDTH-1:0] idx;
    rr_next = ptr;
    for (int i = REQ_NUM_MAX - 1; i >= 0; i--) begin
      idx = ptr + REQ_IDX_WIDTH'(i);
      if (req_mask[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/axi4_stream_frag_sched_if.sv
// AXI4-Stream bundle; master drives the beat, slave returns tready.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4_stream_frag_sched_rr_arb.sv
// Combinational round-robin pick over req_i; pointer advances past the winner on upd_i.
// Pointer holds the first index to search, so reset value 0 gives requester 0 top priority.
module axi4_stream_rr_arb
  import axi4_stream_frag_sched_pkg::*;
#(
  parameter  int REQ_NUM = 4,
  localparam int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [REQ_NUM-1:0] req_i,
  input  logic               upd_i,
  input  logic [IDX_W-1:0]   upd_idx_i,
  output logic               gnt_vld_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [IDX_W-1:0] r_ptr;

  assign gnt_vld_o = |req_i;
  assign gnt_idx_o = IDX_W'(rr_next(REQ_NUM_MAX'(req_i), REQ_IDX_WIDTH'(r_ptr)));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ptr <= '0;
    end else if (upd_i) begin
      r_ptr <= (upd_idx_i == IDX_W'(REQ_NUM - 1)) ? '0 : upd_idx_i + IDX_W'(1);
    end
  end

endmodule

// File: rtl/axi4_stream_frag_sched.sv
// Packet round-robin mux of REQ_NUM streams onto one fragmenter; 1-cycle grant decision, then pass-through with tready routed to the winner only.
// Optional per-requester packet counters under AXI4_STREAM_FRAG_SCHED_STAT_EN.
module axi4_stream_frag_sched
  import axi4_stream_frag_sched_pkg::*;
#(
  parameter  int REQ_NUM           = 4,
  parameter  int DATA_WIDTH        = 32,
  parameter  int ID_WIDTH          = 1,
  parameter  int DEST_WIDTH        = 4,
  parameter  int USER_WIDTH        = 1,
  parameter  int FRAG_SIZE_WIDTH   = 11,
  parameter  int DEFAULT_FRAG_SIZE = 1024,
  localparam int IDX_W             = $clog2(REQ_NUM),
  localparam int FS_W              = FRAG_SIZE_WIDTH + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_wr_i,
  input  logic [IDX_W-1:0]   cfg_addr_i,
  input  logic [FS_W-1:0]    cfg_data_i,
  output logic [FS_W-1:0]    max_frag_size_o,
  output logic [REQ_NUM-1:0] grant_o,
  output logic               busy_o,
`ifdef AXI4_STREAM_FRAG_SCHED_STAT_EN
  input  logic [IDX_W-1:0]   stat_rd_addr_i,
  input  logic               stat_clr_i,
  output logic [31:0]        stat_rd_data_o,
`endif
  axi4_stream_if.slave       pkt_i [REQ_NUM],
  axi4_stream_if.master      pkt_o
);

  localparam int KW = DATA_WIDTH / 8;

  sched_state_t       r_state;
  logic               r_busy;
  logic [REQ_NUM-1:0] r_grant;
  logic [IDX_W-1:0]   r_idx;
  logic [FS_W-1:0]    r_frag;
  logic [FS_W-1:0]    r_tbl [REQ_NUM];

  logic [REQ_NUM-1:0]    w_vld;
  logic [REQ_NUM-1:0]    w_last;
  logic [REQ_NUM-1:0]    w_elig;
  logic [DATA_WIDTH-1:0] w_dat  [REQ_NUM];
  logic [KW-1:0]         w_keep [REQ_NUM];
  logic [KW-1:0]         w_strb [REQ_NUM];
  logic [ID_WIDTH-1:0]   w_id   [REQ_NUM];
  logic [USER_WIDTH-1:0] w_user [REQ_NUM];
  logic                  w_any;
  logic [IDX_W-1:0]      w_pick;
  logic                  w_out_vld;
  logic                  w_eop;

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
    logic [DEST_WIDTH-1:0] w_unused_tdest;
    assign w_unused_tdest   = pkt_i[g].tdest;
    assign w_vld[g]         = pkt_i[g].tvalid;
    assign w_last[g]        = pkt_i[g].tlast;
    assign w_dat[g]         = pkt_i[g].tdata;
    assign w_keep[g]        = pkt_i[g].tkeep;
    assign w_strb[g]        = pkt_i[g].tstrb;
    assign w_id[g]          = pkt_i[g].tid;
    assign w_user[g]        = pkt_i[g].tuser;
    // A zero table entry masks the requester from arbitration.
    assign w_elig[g]        = pkt_i[g].tvalid && (r_tbl[g] != '0);
    assign pkt_i[g].tready  = r_grant[g] & pkt_o.tready;
  end

  axi4_stream_rr_arb #(.REQ_NUM(REQ_NUM)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (w_elig),
    .upd_i     (w_eop),
    .upd_idx_i (r_idx),
    .gnt_vld_o (w_any),
    .gnt_idx_o (w_pick)
  );

  assign w_out_vld    = r_busy & w_vld[r_idx];
  assign w_eop        = w_out_vld & pkt_o.tready & w_last[r_idx];

  assign pkt_o.tvalid = w_out_vld;
  assign pkt_o.tdata  = w_dat[r_idx];
  assign pkt_o.tkeep  = w_keep[r_idx];
  assign pkt_o.tstrb  = w_strb[r_idx];
  assign pkt_o.tlast  = w_last[r_idx];
  assign pkt_o.tid    = w_id[r_idx];
  assign pkt_o.tuser  = w_user[r_idx];
  assign pkt_o.tdest  = DEST_WIDTH'(r_idx);

  assign max_frag_size_o = r_frag;
  assign grant_o         = r_grant;
  assign busy_o          = r_busy;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < REQ_NUM; i++) r_tbl[i] <= FS_W'(DEFAULT_FRAG_SIZE);
    end else if (cfg_wr_i) begin
      r_tbl[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Fragment size is latched only at grant so it stays fixed for the whole packet.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_idx   <= '0;
      r_frag  <= FS_W'(DEFAULT_FRAG_SIZE);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= XFER;
            r_busy  <= 1'b1;
            r_idx   <= w_pick;
            r_grant <= REQ_NUM'(1) << w_pick;
            r_frag  <= r_tbl[w_pick];
          end
        end
        XFER: begin
          if (w_eop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef AXI4_STREAM_FRAG_SCHED_STAT_EN
  logic [31:0] r_cnt [REQ_NUM];
  logic [31:0] r_stat_rd;

  // Clear has priority over a coincident end-of-packet increment.
  always_ff @(posedge clk_i) begin
    if (!rst_i || stat_clr_i) begin
      for (int i = 0; i < REQ_NUM; i++) r_cnt[i] <= '0;
    end else if (w_eop) begin
      r_cnt[r_idx] <= r_cnt[r_idx] + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_stat_rd <= '0;
    else        r_stat_rd <= r_cnt[stat_rd_addr_i];
  end

  assign stat_rd_data_o = r_stat_rd;
`endif

endmodule

// File: tb/tb_axi4_stream_frag_sched.sv
// Randomized bench for axi4_stream_frag_sched: per-requester packet queues, scoreboard and grant/fragment-size logs.
`timescale 1ns/1ps
module tb_axi4_stream_frag_sched;

  localparam int N   = 4;
  localparam int DEF = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_data;
  wire  [11:0] max_frag;
  wire  [3:0]  grant;
  wire         busy;
`ifdef AXI4_STREAM_FRAG_SCHED_STAT_EN
  logic [1:0]  stat_addr;
  logic        stat_clr;
  wire  [31:0] stat_data;
`endif

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(4), .USER_WIDTH(1)) req_if [N] ();
  axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(4), .USER_WIDTH(1)) out_if ();

  // Beat word: {tkeep[4], tstrb[4], tid, tuser, tlast, tdata[32]}
  logic [42:0]  drv_word [N];
  logic [N-1:0] drv_vld;
  logic [N-1:0] rdy_w;
  logic         out_rdy;

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign req_if[g].tvalid = drv_vld[g];
    assign req_if[g].tdata  = drv_word[g][31:0];
    assign req_if[g].tlast  = drv_word[g][32];
    assign req_if[g].tuser  = drv_word[g][33];
    assign req_if[g].tid    = drv_word[g][34];
    assign req_if[g].tstrb  = drv_word[g][38:35];
    assign req_if[g].tkeep  = drv_word[g][42:39];
    assign req_if[g].tdest  = 4'd0;
    assign rdy_w[g]         = req_if[g].tready;
  end
  assign out_if.tready = out_rdy;

  axi4_stream_frag_sched dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .cfg_wr_i        (cfg_wr),
    .cfg_addr_i      (cfg_addr),
    .cfg_data_i      (cfg_data),
    .max_frag_size_o (max_frag),
    .grant_o         (grant),
    .busy_o          (busy),
`ifdef AXI4_STREAM_FRAG_SCHED_STAT_EN
    .stat_rd_addr_i  (stat_addr),
    .stat_clr_i      (stat_clr),
    .stat_rd_data_o  (stat_data),
`endif
    .pkt_i           (req_if),
    .pkt_o           (out_if)
  );

  int checks = 0;
  int errors = 0;

  logic [42:0] src_q [N][$];
  logic [42:0] exp_q [N][$];
  logic [42:0] obs_q [N][$];
  int grant_log[$];
  int frag_log[$];
  int start_log[$];
  int tbl [N];
  int rdy_seen [N];
  int sw_err, frag_err, grant_err, rdy_err, gap_err, timeout;

  task automatic clear_logs();
    for (int k = 0; k < N; k++) begin
      src_q[k].delete(); exp_q[k].delete(); obs_q[k].delete(); rdy_seen[k] = 0;
    end
    grant_log.delete(); frag_log.delete(); start_log.delete();
    sw_err = 0; frag_err = 0; grant_err = 0; rdy_err = 0; gap_err = 0; timeout = 0;
  endtask

  function automatic int count_diff(input int k);
    int d;
    d = (obs_q[k].size() != exp_q[k].size()) ? 1 : 0;
    for (int i = 0; i < obs_q[k].size() && i < exp_q[k].size(); i++)
      if (obs_q[k][i] !== exp_q[k][i]) d++;
    return d;
  endfunction

  task automatic queue_pkt(input int k, input int len);
    logic [42:0] w;
    for (int i = 0; i < len; i++) begin
      w[31:0]  = $urandom();
      w[32]    = (i == len - 1);
      w[42:33] = 10'($urandom_range(0, 1023));
      src_q[k].push_back(w);
      exp_q[k].push_back(w);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; drv_vld = '0; cfg_wr = 1'b0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) tbl[k] = DEF;
  endtask

  task automatic cfg_write(input int a, input int d);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = 2'(a); cfg_data = 12'(d);
    tbl[a] = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // Drives all queued packets; records what the output port carries.
  task automatic run_traffic(input int gap_pct, input int rdy_pct, input logic [N-1:0] ignore,
                             input int cfg_beat, input int cfg_a, input int cfg_d);
    logic [N-1:0] hs, mid;
    logic in_pkt, last_hs, done, cfg_done;
    int cyc, beats, cur_dest, cur_frag, dst;
    hs = '0; mid = '0; in_pkt = 0; last_hs = 0; cfg_done = 0;
    cyc = 0; beats = 0; cur_dest = 0; cur_frag = 0;
    forever begin
      @(negedge clk);
      cfg_wr = 1'b0;
      for (int k = 0; k < N; k++)
        if (hs[k]) begin
          mid[k] = !src_q[k][0][32];
          void'(src_q[k].pop_front());
        end
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0 && !(mid[k] && $urandom_range(0, 99) < gap_pct)) begin
          drv_vld[k] = 1'b1; drv_word[k] = src_q[k][0];
        end else begin
          drv_vld[k] = 1'b0;
        end
      end
      out_rdy = ($urandom_range(0, 99) < rdy_pct);
      if (cfg_beat >= 0 && beats == cfg_beat && !cfg_done) begin
        cfg_wr = 1'b1; cfg_addr = 2'(cfg_a); cfg_data = 12'(cfg_d); tbl[cfg_a] = cfg_d; cfg_done = 1;
      end
      #1;
      if (last_hs && (out_if.tvalid || grant != 4'b0)) gap_err++;
      for (int k = 0; k < N; k++) begin
        if (rdy_w[k] !== (grant[k] & out_rdy)) rdy_err++;
        if (rdy_w[k]) rdy_seen[k]++;
      end
      if (in_pkt && grant != (4'b1 << cur_dest)) grant_err++;
      if (in_pkt && int'(max_frag) != cur_frag) frag_err++;
      if (out_if.tvalid) begin
        if (!in_pkt) begin
          in_pkt = 1; cur_dest = int'(out_if.tdest); cur_frag = int'(max_frag);
          grant_log.push_back(cur_dest); frag_log.push_back(cur_frag); start_log.push_back(cyc);
          if (grant != (4'b1 << cur_dest)) grant_err++;
        end else if (int'(out_if.tdest) != cur_dest) begin
          sw_err++;
        end
      end
      last_hs = 0;
      if (out_if.tvalid && out_rdy) begin
        dst = int'(out_if.tdest);
        if (dst < N)
          obs_q[dst].push_back({out_if.tkeep, out_if.tstrb, out_if.tid, out_if.tuser, out_if.tlast, out_if.tdata});
        else
          sw_err++;
        beats++;
        if (out_if.tlast) begin in_pkt = 0; last_hs = 1; end
      end
      for (int k = 0; k < N; k++) hs[k] = drv_vld[k] && rdy_w[k];
      done = !in_pkt;
      for (int k = 0; k < N; k++)
        if (!ignore[k] && (src_q[k].size() - int'(hs[k])) > 0) done = 0;
      if (done) break;
      cyc++;
      if (cyc > 5000) begin timeout = 1; break; end
    end
    @(negedge clk);
    drv_vld = '0; cfg_wr = 1'b0; out_rdy = 1'b1;
    for (int k = 0; k < N; k++) src_q[k].delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; drv_vld = '1; out_rdy = 1'b1; cfg_wr = 1'b0;
    for (int k = 0; k < N; k++) drv_word[k] = '0;
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0)       begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", out_if.tvalid); end
    checks++; if (rdy_w !== 4'b0)       begin errors++; $display("FAIL reset_tready got %b want 0000", rdy_w); end
    checks++; if (max_frag !== 12'(DEF)) begin errors++; $display("FAIL reset_frag got %0d want %0d", max_frag, DEF); end
    drv_vld = '0;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) tbl[k] = DEF;
  endtask

  task automatic test_two_req();
    int seq;
    do_reset(); clear_logs();
    queue_pkt(0, 4); queue_pkt(2, 4);
    run_traffic(0, 100, '0, -1, 0, 0);
    seq = (grant_log.size() == 2) ? grant_log[0] * 10 + grant_log[1] : -1;
    checks++; if (seq != 2) begin errors++; $display("FAIL two_req_order got %0d want 2 (req0 then req2)", seq); end
    seq = (start_log.size() == 2) ? start_log[0] * 100 + start_log[1] : -1;
    checks++; if (seq != 106) begin errors++; $display("FAIL two_req_start got %0d want 106 (cycles 1 and 6)", seq); end
    checks++; if (gap_err != 0 || grant_err != 0) begin errors++; $display("FAIL two_req_gap gap=%0d grant=%0d want 0", gap_err, grant_err); end
    for (int k = 0; k < N; k++) begin
      checks++; if (count_diff(k) != 0) begin errors++; $display("FAIL two_req_data req%0d diffs=%0d want 0", k, count_diff(k)); end
    end
  endtask

  task automatic test_cfg_midpkt();
    clear_logs();
    cfg_write(1, 300);
    queue_pkt(1, 10); queue_pkt(1, 4);
    run_traffic(0, 100, '0, 3, 1, 64);
    checks++; if (frag_log.size() != 2 || frag_log[0] != 300) begin errors++; $display("FAIL cfg_first_frag got %0d want 300", frag_log.size() > 0 ? frag_log[0] : -1); end
    checks++; if (frag_log.size() != 2 || frag_log[1] != 64) begin errors++; $display("FAIL cfg_next_frag got %0d want 64", frag_log.size() > 1 ? frag_log[1] : -1); end
    checks++; if (frag_err != 0) begin errors++; $display("FAIL cfg_frag_stable changes=%0d want 0", frag_err); end
    checks++; if (count_diff(1) != 0) begin errors++; $display("FAIL cfg_data diffs=%0d want 0", count_diff(1)); end
  endtask

  task automatic test_mask();
    int hits;
    clear_logs();
    cfg_write(3, 0);
    for (int k = 0; k < N; k++) begin queue_pkt(k, 3); queue_pkt(k, 2); end
    run_traffic(0, 100, 4'b1000, -1, 0, 0);
    hits = 0;
    foreach (grant_log[i]) if (grant_log[i] == 3) hits++;
    checks++; if (hits != 0) begin errors++; $display("FAIL mask_grant got %0d grants of req3 want 0", hits); end
    checks++; if (rdy_seen[3] != 0) begin errors++; $display("FAIL mask_tready got %0d cycles want 0", rdy_seen[3]); end
    checks++; if (obs_q[3].size() != 0) begin errors++; $display("FAIL mask_data got %0d beats want 0", obs_q[3].size()); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (count_diff(k) != 0) begin errors++; $display("FAIL mask_data req%0d diffs=%0d want 0", k, count_diff(k)); end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset(); clear_logs();
    for (int p = 0; p < 4; p++) for (int k = 0; k < N; k++) queue_pkt(k, 2);
    run_traffic(0, 100, '0, -1, 0, 0);
    bad = (grant_log.size() == 16) ? 0 : 100;
    foreach (grant_log[i]) if (grant_log[i] != i % N) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rr_order got %0d bad grants (of %0d) want 0", bad, grant_log.size()); end
    checks++; if (timeout != 0 || gap_err != 0) begin errors++; $display("FAIL rr_flow timeout=%0d gap=%0d want 0", timeout, gap_err); end
    for (int k = 0; k < N; k++) begin
      checks++; if (count_diff(k) != 0) begin errors++; $display("FAIL rr_data req%0d diffs=%0d want 0", k, count_diff(k)); end
    end
  endtask

  task automatic test_random();
    int bad;
    clear_logs();
    for (int k = 0; k < N; k++) cfg_write(k, $urandom_range(1, 4095));
    for (int p = 0; p < 6; p++) for (int k = 0; k < N; k++) queue_pkt(k, $urandom_range(1, 6));
    run_traffic(30, 60, '0, -1, 0, 0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL rand_timeout got %0d want 0", timeout); end
    checks++; if (sw_err != 0) begin errors++; $display("FAIL rand_switch got %0d want 0", sw_err); end
    checks++; if (grant_err != 0 || rdy_err != 0) begin errors++; $display("FAIL rand_grant grant=%0d tready=%0d want 0", grant_err, rdy_err); end
    bad = frag_err;
    foreach (grant_log[i]) if (frag_log[i] != tbl[grant_log[i]]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_frag got %0d bad want 0", bad); end
    checks++; if (grant_log.size() != 24) begin errors++; $display("FAIL rand_pkts got %0d want 24", grant_log.size()); end
    for (int k = 0; k < N; k++) begin
      checks++; if (count_diff(k) != 0) begin errors++; $display("FAIL rand_data req%0d diffs=%0d want 0", k, count_diff(k)); end
    end
  endtask

  task automatic test_mid_reset();
    int n, cyc;
    clear_logs();
    cfg_write(1, 300);
    @(negedge clk);
    drv_word[1] = {10'h0, 1'b0, 32'h0000_00A5};
    drv_vld[1] = 1'b1; out_rdy = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      #1;
      if (out_if.tvalid && out_rdy) n++;
      if (n < 2) begin @(negedge clk); cyc++; end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL midrst_start got %0d beats want 2", n); end
    checks++; if (busy !== 1'b1 || max_frag !== 12'd300) begin errors++; $display("FAIL midrst_pre busy=%b frag=%0d want 1/300", busy, max_frag); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0 || out_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_idle grant=%b tvalid=%b want 0000/0", grant, out_if.tvalid); end
    checks++; if (max_frag !== 12'(DEF)) begin errors++; $display("FAIL midrst_frag got %0d want %0d", max_frag, DEF); end
`ifdef AXI4_STREAM_FRAG_SCHED_STAT_EN
    checks++; if (stat_data !== 32'd0) begin errors++; $display("FAIL midrst_stat got %0d want 0", stat_data); end
`endif
    rst_n = 1'b1; drv_vld = '0;
    for (int k = 0; k < N; k++) tbl[k] = DEF;
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; drv_vld = '0; out_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin drv_word[k] = '0; tbl[k] = DEF; end
`ifdef AXI4_STREAM_FRAG_SCHED_STAT_EN
    stat_addr = '0; stat_clr = 1'b0;
`endif
    test_reset();
    test_two_req();
    test_cfg_midpkt();
    test_mask();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
